// File: rtl/pcs_rx_sync.sv
// pcs_rx_sync: receive code-group synchronization state machine with
// code-group forwarding, even/odd tracking and a saturating error count.
module pcs_rx_sync #(
    parameter logic [15:0] ERR_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cg_valid,
    input  logic [7:0]  cg_data,
    input  logic        cg_control,
    input  logic        cg_invalid,
    input  logic        cg_comma,
    output logic        sync_ok,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_control,
    output logic        rx_even,
    output logic [3:0]  state,
    output logic [15:0] err_count
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC    = 4'd0,
        COMMA_DETECT_1  = 4'd1,
        ACQUIRE_SYNC_1  = 4'd2,
        COMMA_DETECT_2  = 4'd3,
        ACQUIRE_SYNC_2  = 4'd4,
        COMMA_DETECT_3  = 4'd5,
        SYNC_ACQUIRED_1 = 4'd6,
        SYNC_ACQUIRED_2 = 4'd7,
        SYNC_ACQUIRED_3 = 4'd8,
        SYNC_ACQUIRED_4 = 4'd9
    } state_t;

    state_t     cur_q;
    state_t     nxt;
    state_t     sa_up;
    state_t     sa_down;
    logic [1:0] good_q;
    logic [1:0] good_d;
    logic       even_d;
    logic       comma;
    logic       cgbad;
    logic       data_cg;
    logic       in_sync;
    logic       nxt_sync;

    function automatic logic is_sync(input state_t s);
        return s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2,
                         SYNC_ACQUIRED_3, SYNC_ACQUIRED_4};
    endfunction

    // An invalid group never counts as a comma, even if flagged as one.
    assign comma    = cg_comma & ~cg_invalid;
    assign cgbad    = cg_invalid | (comma & rx_even);
    assign data_cg  = ~cg_control & ~cg_invalid;
    assign in_sync  = is_sync(cur_q);
    assign nxt_sync = is_sync(nxt);
    assign even_d   = (comma & ~in_sync) ? 1'b1 : ~rx_even;
    assign state    = cur_q;

    always_comb begin
        sa_up   = LOSS_OF_SYNC;
        sa_down = SYNC_ACQUIRED_1;
        unique case (cur_q)
            SYNC_ACQUIRED_2: begin
                sa_up   = SYNC_ACQUIRED_3;
                sa_down = SYNC_ACQUIRED_1;
            end
            SYNC_ACQUIRED_3: begin
                sa_up   = SYNC_ACQUIRED_4;
                sa_down = SYNC_ACQUIRED_2;
            end
            SYNC_ACQUIRED_4: begin
                sa_up   = LOSS_OF_SYNC;
                sa_down = SYNC_ACQUIRED_3;
            end
            default: begin
                sa_up   = LOSS_OF_SYNC;
                sa_down = SYNC_ACQUIRED_1;
            end
        endcase
    end

    always_comb begin
        nxt    = cur_q;
        good_d = good_q;
        unique case (cur_q)
            LOSS_OF_SYNC: begin
                if (comma) nxt = COMMA_DETECT_1;
            end
            COMMA_DETECT_1: begin
                nxt = data_cg ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            end
            COMMA_DETECT_2: begin
                nxt = data_cg ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            end
            COMMA_DETECT_3: begin
                nxt = data_cg ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            end
            ACQUIRE_SYNC_1: begin
                if (cgbad)
                    nxt = LOSS_OF_SYNC;
                else if (comma && !rx_even)
                    nxt = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
                if (cgbad)
                    nxt = LOSS_OF_SYNC;
                else if (comma && !rx_even)
                    nxt = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1: begin
                if (cgbad) begin
                    nxt    = SYNC_ACQUIRED_2;
                    good_d = 2'd0;
                end
            end
            SYNC_ACQUIRED_2,
            SYNC_ACQUIRED_3,
            SYNC_ACQUIRED_4: begin
                if (cgbad) begin
                    nxt    = sa_up;
                    good_d = 2'd0;
                end else if (good_q == 2'd3) begin
                    nxt    = sa_down;
                    good_d = 2'd0;
                end else begin
                    good_d = good_q + 2'd1;
                end
            end
            default: begin
                nxt = comma ? COMMA_DETECT_1 : LOSS_OF_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q   <= LOSS_OF_SYNC;
            good_q  <= 2'd0;
            rx_even <= 1'b0;
            sync_ok <= 1'b0;
        end else if (cg_valid) begin
            cur_q   <= nxt;
            good_q  <= good_d;
            rx_even <= even_d;
            sync_ok <= nxt_sync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            rx_control <= 1'b0;
        end else begin
            rx_valid <= cg_valid & nxt_sync & ~cg_invalid;
            if (cg_valid) begin
                rx_data    <= cg_data;
                rx_control <= cg_control;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= 16'd0;
        end else if (cg_valid && cgbad && in_sync) begin
            if (err_count < ERR_MAX)
                err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: doc/pcs_rx_sync.md
PCS_RX_SYNC -- requirements
Module: pcs_rx_sync

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, deassertion is synchronous to clk.
REQ-003 cg_valid  input  1  strobe marking one decoded code group on the cg_* inputs this cycle.
REQ-004 cg_data  input  8  decoded byte from the 8b/10b decoder.
REQ-005 cg_control  input  1  decoder K-character flag.
REQ-006 cg_invalid  input  1  decoder invalid-code-group flag.
REQ-007 cg_comma  input  1  code group contains a comma (K28.1/K28.5/K28.7).
REQ-008 sync_ok  output  1  link synchronized (states SYNC_ACQUIRED_x).
REQ-009 rx_valid  output  1  forwarded code group valid.
REQ-010 rx_data  output  8  forwarded byte.
REQ-011 rx_control  output  1  forwarded K flag.
REQ-012 rx_even  output  1  even/odd code-group alignment flag.
REQ-013 state  output  4  current FSM state encoding (REQ-016).
REQ-014 err_count  output  16  saturating count of cgbad events while sync_ok=1.

Function
REQ-015 All FSM actions occur only on clk edges with cg_valid=1; cg_valid=0 holds all state and drives rx_valid=0 next cycle.
REQ-016 State encodings: LOSS_OF_SYNC=0, COMMA_DETECT_1=1, ACQUIRE_SYNC_1=2, COMMA_DETECT_2=3, ACQUIRE_SYNC_2=4, COMMA_DETECT_3=5, SYNC_ACQUIRED_1=6, SYNC_ACQUIRED_2=7, SYNC_ACQUIRED_3=8, SYNC_ACQUIRED_4=9; others unused, decode to LOSS_OF_SYNC.
REQ-017 Definitions per code group: cgbad = cg_invalid OR (cg_comma AND rx_even=1); cggood = NOT cgbad.
REQ-018 rx_even: set to 1 (even) on any accepted comma while not sync_ok... more precisely, on every accepted code group rx_even toggles, except that a cg_comma in states 0-5 forces rx_even to 1.
REQ-019 LOSS_OF_SYNC: cg_comma AND NOT cg_invalid -> COMMA_DETECT_1; else stay.
REQ-020 COMMA_DETECT_n (n=1,2,3): data code group (NOT cg_control AND NOT cg_invalid) -> ACQUIRE_SYNC_n (n=1,2) or SYNC_ACQUIRED_1 (n=3); any other -> LOSS_OF_SYNC.
REQ-021 ACQUIRE_SYNC_n (n=1,2): cgbad -> LOSS_OF_SYNC; cg_comma with rx_even=0 (odd slot) -> COMMA_DETECT_n+1; else stay.
REQ-022 SYNC_ACQUIRED_1: cgbad -> SYNC_ACQUIRED_2 with good_cgs cleared; else stay.
REQ-023 SYNC_ACQUIRED_m (m=2,3,4): internal 2-bit good_cgs; cgbad -> SYNC_ACQUIRED_m+1 (m=4: LOSS_OF_SYNC), good_cgs=0; cggood with good_cgs=3 -> SYNC_ACQUIRED_m-1, good_cgs=0; cggood otherwise good_cgs+1, stay.
REQ-024 sync_ok = 1 exactly when state is 6..9; registered, reflects state after the edge.
REQ-025 Datapath: rx_data/rx_control registered copies of cg_data/cg_control, one-cycle latency; rx_valid=1 only when cg_valid=1 AND the next state has sync_ok=1 AND cg_invalid=0.
REQ-026 err_count increments by 1 on each cgbad while current state is 6..9; holds at 16'hFFFF (no wrap).
REQ-027 Simultaneous cg_invalid and cg_comma: treated as cgbad; invalid takes precedence, never counts as comma.

Reset
REQ-028 On reset=0: state=0, good_cgs=0, rx_even=0, sync_ok=0, rx_valid=0, rx_data=8'h00, rx_control=0, err_count=0.
REQ-029 Reset asserted mid-operation (any state) returns to LOSS_OF_SYNC within the same cycle, discarding in-flight code group.

Verification
REQ-030 Reset then K28.5,D,K28.5,D,K28.5,D (cg_valid every cycle) -> state 0,1,2,3,4,5,6; sync_ok=1 after 6th group; rx_valid=1 from that group on.
REQ-031 In SYNC_ACQUIRED_1, one cg_invalid then 4 good groups -> state 7 then back to 6 after 4th good; err_count=1.
REQ-032 In SYNC_ACQUIRED_1, three cgbad groups each separated by 1 good group -> state 7,8,9, then 4th cgbad -> state 0, sync_ok=0, rx_valid=0.
REQ-033 In ACQUIRE_SYNC_1, comma in even slot (rx_even=1) -> LOSS_OF_SYNC; in COMMA_DETECT_2, K-char follows comma -> LOSS_OF_SYNC.
REQ-034 Force 65540 cgbad/good alternations keeping state in 6..9 -> err_count saturates at 16'hFFFF.
REQ-035 Deassert cg_valid for 10 cycles in state 7 with good_cgs=2 -> state, good_cgs, rx_even unchanged, rx_valid=0; reset pulse mid-stream -> all outputs per REQ-028 immediately.
